// File: rtl/piso32_tx_pkg.sv
// Shared types and constants for the piso32_tx serial transmitter.
//   state_e    : transmitter FSM state (IDLE / SHIFT)
//   DEF_WIDTH  : default word width
//   cnt_width  : bit-counter width for a given word width
package piso32_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;

  // Counter must index 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 32'd2) ? 32'd1 : 32'($clog2(w));
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load shift register with a single serial tap.
//   clk, rst   : clock, asynchronous active-low clear
//   load       : capture load_data
//   load_data  : parallel word
//   shift      : move one bit toward the tap end, zero-filling
//   clear      : synchronous clear to zero
//   tap        : serial output bit (bit 0, or bit WIDTH-1 when MSB_FIRST)
module piso_shreg
  import piso32_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             clear,
  output logic             tap
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;

  // Clear wins over load, load wins over shift.
  always_comb begin
    reg_d = reg_q;
    if (clear) begin
      reg_d = '0;
    end else if (load) begin
      reg_d = load_data;
    end else if (shift) begin
      if (MSB_FIRST) begin
        reg_d = {reg_q[WIDTH-2:0], 1'b0};
      end else begin
        reg_d = {1'b0, reg_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign tap = MSB_FIRST ? reg_q[WIDTH-1] : reg_q[0];

endmodule

// File: rtl/piso32_tx.sv
// Parallel-in/serial-out transmitter with valid/ready input and framed serial output.
//   clk, rst    : clock, asynchronous active-low reset
//   in_data     : word to transmit, sampled on accept
//   in_valid    : in_data is valid
//   in_ready    : a word can be accepted this cycle (depends on shift_en)
//   shift_en    : advance-one-bit strobe
//   sout        : serial data bit
//   sout_valid  : sout carries a frame bit
//   sout_first  : first bit of the frame
//   sout_last   : last bit of the frame
module piso32_tx
  import piso32_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic sr_load;
  logic sr_shift;
  logic sr_clear;
  logic sr_tap;
  logic last_bit;
  logic accept;

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .load_data (in_data),
    .shift     (sr_shift),
    .clear     (sr_clear),
    .tap       (sr_tap)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and shift-register controls.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sr_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (cnt_q < LAST) begin
            sr_shift = 1'b1;
            cnt_d    = cnt_q + CW'(1);
          end else if (accept) begin
            // Gapless reload on the last-bit edge.
            sr_load = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d  = ST_IDLE;
            sr_clear = 1'b1;
            cnt_d    = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: frame flags decode registered state; in_ready also sees shift_en.
  always_comb begin
    sout_valid = (state_q == ST_SHIFT);
    last_bit   = sout_valid && (cnt_q == LAST);
    sout       = sout_valid & sr_tap;
    sout_first = sout_valid && (cnt_q == '0);
    sout_last  = last_bit;
    in_ready   = (state_q == ST_IDLE) || (last_bit && shift_en);
    accept     = in_valid && in_ready;
  end

endmodule

// File: tb/tb_piso32_tx.sv
module tb_piso32_tx;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          shift_en;

  logic in_ready_l, sout_l, sout_valid_l, sout_first_l, sout_last_l;
  logic in_ready_m, sout_m, sout_valid_m, sout_first_m, sout_last_m;

  always #5 clk = ~clk;

  piso32_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .shift_en(shift_en), .sout(sout_l),
    .sout_valid(sout_valid_l), .sout_first(sout_first_l), .sout_last(sout_last_l)
  );

  piso32_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .shift_en(shift_en), .sout(sout_m),
    .sout_valid(sout_valid_m), .sout_first(sout_first_m), .sout_last(sout_last_m)
  );

  // Observed vector layout: {ready, valid, sout, first, last}
  wire [4:0] obs_l = {in_ready_l, sout_valid_l, sout_l, sout_first_l, sout_last_l};
  wire [4:0] obs_m = {in_ready_m, sout_valid_m, sout_m, sout_first_m, sout_last_m};

  int errors = 0;
  int checks = 0;

  // Reference model: which word is in flight and which bit index is on the wire.
  bit           m_active = 1'b0;
  logic [W-1:0] m_word   = '0;
  int           m_k      = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         se;
    logic [4:0]   exp;
  } vec_t;

  vec_t tbl[34];

  task automatic check5(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] model_exp(input bit msb, input logic se);
    logic ready, b;
    ready = !m_active || ((m_k == W - 1) && se);
    b = msb ? m_word[W - 1 - m_k] : m_word[m_k];
    return {ready, m_active, m_active & b, m_active && (m_k == 0), m_active && (m_k == W - 1)};
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_word   = '0;
    m_k      = 0;
  endtask

  task automatic model_advance(input logic v, input logic [W-1:0] d, input logic se);
    bit ready, acc;
    if (!rst) begin
      model_reset();
      return;
    end
    ready = !m_active || ((m_k == W - 1) && se);
    acc   = v && ready;
    if (m_active && se) begin
      if (m_k < W - 1) m_k++;
      else m_active = 1'b0;
    end
    if (acc) begin
      m_active = 1'b1;
      m_word   = d;
      m_k      = 0;
    end
  endtask

  // One clock: drive inputs, sample on the falling edge, check both DUTs, advance model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic se,
                      output logic [4:0] ol, output logic [4:0] om);
    in_valid = v;
    in_data  = d;
    shift_en = se;
    @(negedge clk);
    ol = obs_l;
    om = obs_m;
    check5("model_lsb", ol, model_exp(1'b0, se));
    check5("model_msb", om, model_exp(1'b1, se));
    model_advance(v, d, se);
    @(posedge clk);
    #1;
  endtask

  task automatic drop_rst();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0]  ol, om;
    logic [31:0] acc_bits;
    logic [31:0] w;
    int          n, run, maxrun, rdy;
    logic        v;

    // Reset held while clocking with in_valid high: nothing may be accepted.
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h1234_5678;
    shift_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h1234_5678, 1'b1, ol, om);
      check5("in_reset", ol, 5'b10000);
    end
    rst = 1'b1;
    step(1'b0, '0, 1'b1, ol, om);
    check5("idle_after_rst", ol, 5'b10000);

    // LSB-first frame as a vector table.
    w = 32'hA5A5_0F01;
    tbl[0] = '{v: 1'b1, d: w, se: 1'b1, exp: 5'b10000};
    for (int k = 0; k < W; k++) begin
      tbl[k+1] = '{v: 1'b0, d: '0, se: 1'b1,
                   exp: {(k == W - 1), 1'b1, w[k], (k == 0), (k == W - 1)}};
    end
    tbl[33] = '{v: 1'b0, d: '0, se: 1'b1, exp: 5'b10000};
    for (int i = 0; i < 34; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].se, ol, om);
      check5($sformatf("vec%0d", i), ol, tbl[i].exp);
    end

    // MSB-first: reassemble the word from the serial stream.
    step(1'b1, 32'h8000_0001, 1'b1, ol, om);
    acc_bits = '0;
    for (int k = 0; k < W; k++) begin
      step(1'b0, '0, 1'b1, ol, om);
      acc_bits = {acc_bits[30:0], om[2]};
    end
    check32("msb_word", acc_bits, 32'h8000_0001);

    // Stall: bit 15 held for 4 cycles, frame stretches to 35 cycles.
    step(1'b1, 32'hFFFF_0000, 1'b1, ol, om);
    for (int k = 0; k < 15; k++) step(1'b0, '0, 1'b1, ol, om);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b0, ol, om);
      check5($sformatf("stall_hold%0d", k), ol, 5'b01000);
    end
    n = 18;
    for (int g = 0; g < 60; g++) begin
      step(1'b0, '0, 1'b1, ol, om);
      if (ol[3]) n++;
      else break;
    end
    check32("stall_len", 32'(n), 32'd35);

    // Back-to-back frames with in_valid held through the first frame.
    step(1'b1, 32'h0000_0001, 1'b1, ol, om);
    run = 0; maxrun = 0; rdy = 0;
    for (int i = 0; i < 70; i++) begin
      v = (i < 32);
      step(v, 32'h8000_0000, 1'b1, ol, om);
      if (v && ol[4]) rdy++;
      if (ol[3]) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check32("b2b_run", 32'(maxrun), 32'd64);
    check32("b2b_ready_pulses", 32'(rdy), 32'd1);

    // Reset in the middle of a frame.
    step(1'b1, 32'hDEAD_BEEF, 1'b1, ol, om);
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, ol, om);
    check5("pre_abort_valid", {4'b0, obs_l[3]}, 5'b00001);
    drop_rst();
    #1;
    check5("abort_l", obs_l, 5'b10000);
    check5("abort_m", obs_m, 5'b10000);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, ol, om);
    step(1'b0, '0, 1'b1, ol, om);
    rst = 1'b1;
    step(1'b1, 32'h1234_5679, 1'b1, ol, om);
    step(1'b0, '0, 1'b1, ol, om);
    check5("after_abort_first", ol, 5'b01110);
    for (int k = 1; k < W + 2; k++) step(1'b0, '0, 1'b1, ol, om);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        drop_rst();
        step(1'b1, $urandom, 1'b1, ol, om);
        rst = 1'b1;
      end
      step(($urandom % 3) != 0, $urandom, ($urandom % 4) != 0, ol, om);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
